// File: rtl/fcs_check_strip.sv
// Ethernet FCS checker/stripper: runs CRC-32 over each received frame, forwards the payload
// with the trailing 4 FCS bytes removed, and reports per-frame status plus good/bad counts.
module fcs_check_strip #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    input  logic             in_sop,
    input  logic             in_eop,
    output logic             out_valid,
    output logic [7:0]       out_data,
    output logic             out_sop,
    output logic             out_eop,
    output logic             stat_valid,
    output logic             stat_good,
    output logic             stat_runt,
    output logic             stat_abort,
    output logic [CNT_W-1:0] good_cnt,
    output logic [CNT_W-1:0] bad_cnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        STREAM = 2'd2
    } state_t;

    localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_POLY    = 32'h04C1_1DB7;
    localparam logic [31:0] CRC_RESIDUE = 32'hC704_DD7B;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Eight serial LFSR steps, data LSB first, feedback taken from the register MSB.
    function automatic logic [31:0] crcByte(input logic [31:0] crcIn, input logic [7:0] data);
        logic [31:0] c;
        logic        fb;
        c = crcIn;
        for (int i = 0; i < 8; i++) begin
            fb = c[31] ^ data[i];
            c  = {c[30:0], 1'b0} ^ (fb ? CRC_POLY : 32'h0);
        end
        return c;
    endfunction

    state_t      state_q, state_d;
    logic [31:0] crc_q, crc_d;
    logic [7:0]  dly_q [4];
    logic [7:0]  dly_d [4];
    logic [2:0]  fillCnt_q, fillCnt_d;

    logic        outValid_q, outValid_d;
    logic [7:0]  outData_q, outData_d;
    logic        outSop_q, outSop_d;
    logic        outEop_q, outEop_d;
    logic        statValid_q, statValid_d;
    logic        statGood_q, statGood_d;
    logic        statRunt_q, statRunt_d;
    logic        statAbort_q, statAbort_d;
    logic [CNT_W-1:0] goodCnt_q, badCnt_q;

    logic [31:0] crcStep;
    logic        inFrame;
    logic        fifthOrLater;

    // A new in_sop restarts the CRC from the preload value regardless of the current state.
    assign crcStep      = crcByte(in_sop ? CRC_INIT : crc_q, in_data);
    assign inFrame      = (state_q != IDLE);
    assign fifthOrLater = (state_q == STREAM) || (fillCnt_q == 3'd4);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            crc_q     <= CRC_INIT;
            fillCnt_q <= 3'd0;
            for (int i = 0; i < 4; i++) begin
                dly_q[i] <= 8'h00;
            end
        end else begin
            state_q   <= state_d;
            crc_q     <= crc_d;
            fillCnt_q <= fillCnt_d;
            dly_q     <= dly_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        crc_d     = crc_q;
        dly_d     = dly_q;
        fillCnt_d = fillCnt_q;
        if (in_valid && (in_sop || inFrame)) begin
            crc_d    = crcStep;
            dly_d[0] = in_data;
            for (int i = 1; i < 4; i++) begin
                dly_d[i] = dly_q[i-1];
            end
            if (in_sop) begin
                fillCnt_d = 3'd1;
                state_d   = in_eop ? IDLE : FILL;
            end else begin
                fillCnt_d = (fillCnt_q == 3'd4) ? 3'd4 : fillCnt_q + 3'd1;
                if (in_eop) begin
                    state_d = IDLE;
                end else if (fifthOrLater) begin
                    state_d = STREAM;
                end
            end
        end
    end

    // A one-byte frame that also aborts its predecessor is reported in a single strobe
    // carrying both the abort and runt flags.
    always_comb begin
        outValid_d  = 1'b0;
        outData_d   = dly_q[3];
        outSop_d    = 1'b0;
        outEop_d    = 1'b0;
        statValid_d = 1'b0;
        statGood_d  = 1'b0;
        statRunt_d  = 1'b0;
        statAbort_d = 1'b0;
        if (in_valid) begin
            if (in_sop) begin
                if (inFrame) begin
                    statValid_d = 1'b1;
                    statAbort_d = 1'b1;
                    statRunt_d  = in_eop;
                end else if (in_eop) begin
                    statValid_d = 1'b1;
                    statRunt_d  = 1'b1;
                end
            end else if (inFrame) begin
                if (fifthOrLater) begin
                    outValid_d = 1'b1;
                    outSop_d   = (state_q == FILL);
                    if (in_eop) begin
                        outEop_d    = 1'b1;
                        statValid_d = 1'b1;
                        statGood_d  = (crcStep == CRC_RESIDUE);
                    end
                end else if (in_eop) begin
                    statValid_d = 1'b1;
                    statRunt_d  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outValid_q  <= 1'b0;
            outData_q   <= 8'h00;
            outSop_q    <= 1'b0;
            outEop_q    <= 1'b0;
            statValid_q <= 1'b0;
            statGood_q  <= 1'b0;
            statRunt_q  <= 1'b0;
            statAbort_q <= 1'b0;
        end else begin
            outValid_q  <= outValid_d;
            outData_q   <= outData_d;
            outSop_q    <= outSop_d;
            outEop_q    <= outEop_d;
            statValid_q <= statValid_d;
            statGood_q  <= statGood_d;
            statRunt_q  <= statRunt_d;
            statAbort_q <= statAbort_d;
        end
    end

    // Counters advance together with the status strobe they account for.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            goodCnt_q <= '0;
            badCnt_q  <= '0;
        end else if (statValid_d) begin
            if (statGood_d) begin
                if (goodCnt_q != CNT_MAX) begin
                    goodCnt_q <= goodCnt_q + CNT_ONE;
                end
            end else if (badCnt_q != CNT_MAX) begin
                badCnt_q <= badCnt_q + CNT_ONE;
            end
        end
    end

    assign out_valid  = outValid_q;
    assign out_data   = outData_q;
    assign out_sop    = outSop_q;
    assign out_eop    = outEop_q;
    assign stat_valid = statValid_q;
    assign stat_good  = statGood_q;
    assign stat_runt  = statRunt_q;
    assign stat_abort = statAbort_q;
    assign good_cnt   = goodCnt_q;
    assign bad_cnt    = badCnt_q;

endmodule
